vlc_expand: RTL and testbench
=============================

// Module: vlc_expand
// PURPOSE
//  Run-length expander. Inverse of the VLC run counter: accepts (type, count) run tokens and
//  regenerates the serial bitstream, one bit per cycle, with downstream backpressure.
//  Sits between the token channel (decoded fields) and the serial-bit consumer.
// PARAMETERS
//  COUNT_W     8  run-length field width; equals the VLC third-field size
//  FIFO_DEPTH  4  token FIFO entries, power of 2, >=2; used only with VLC_EXPAND_FIFO_EN
// PORTS
//  clk         in   1        clock, all logic on rising edge
//  rst         in   1        synchronous reset, active-high
//  type_in     in   1        run bit value (1 = ones run, 0 = zeros run)
//  count_in    in   COUNT_W  run length in bits; 0 is illegal
//  din_valid   in   1        token valid
//  din_ready   out  1        token accepted when din_valid & din_ready
//  data_out    out  1        regenerated serial bit
//  dout_valid  out  1        data_out valid
//  dout_ready  in   1        consumer takes bit when dout_valid & dout_ready
//  dout_last   out  1        high with the final bit of each run
//  err_zero    out  1        1-cycle pulse: count_in==0 token accepted and dropped
// BEHAVIOUR
//  - Reset, sync, active-high: state=IDLE, remaining=0, data_out=0, dout_valid=0, dout_last=0,
//    err_zero=0, FIFO emptied. din_ready=0 while rst is high. Reset mid-run discards the run.
//  - FSM IDLE -> EMIT on an accepted token with count!=0. Load cur_type=type_in, remaining=count_in.
//    The token is accepted from the port or, with the FIFO, from the FIFO head.
//  - FSM EMIT: dout_valid=1, data_out=cur_type, dout_last=(remaining==1).
//    On each dout_ready: remaining-=1. On the last bit (remaining==1 & dout_ready):
//    if a next token is available, load it (no bubble); else go to IDLE.
//  - Latency: a token accepted in cycle N presents its first bit in cycle N+1.
//    A token with count=C occupies exactly C handshake cycles when dout_ready is held at 1.
//  - Outputs hold stable while dout_valid & !dout_ready.
//  - No-FIFO din_ready = IDLE | (EMIT & remaining==1 & dout_ready). This is a combinational
//    path from dout_ready.
//  - count_in==0: the token is accepted and produces no bits. err_zero pulses the next cycle.
//    The FSM state is unchanged.
//  - Width: remaining is COUNT_W bits. The maximum run is 2^COUNT_W-1, so no wrap is possible.
//  - Consecutive tokens of equal type are legal and expand verbatim, with no merge.
// CONFIGURATION
//  VLC_EXPAND_FIFO_EN defined:
//   - A FIFO_DEPTH token FIFO is inserted ahead of the FSM. din_ready = !fifo_full (registered).
//   - Zero-count tokens are dropped at FIFO write.
//   - Accept-to-first-bit latency is 2 cycles when the FIFO is empty.
//  VLC_EXPAND_FIFO_EN undefined:
//   - Tokens are loaded straight from the port. 1-cycle latency. din_ready as described above.
// STRUCTURE
//  - Shared package vlc_pkg:
//     - VLC_COUNT_W constant (the third-field size).
//     - typedef vlc_token_t {logic type; logic [COUNT_W-1:0] count}.
//     - FSM state enum {VLC_EXP_IDLE, VLC_EXP_EMIT}.
//  - Sub-module vlc_token_fifo: synchronous FIFO of vlc_token_t, full/empty flags, sync reset.
//    Instantiated only under VLC_EXPAND_FIFO_EN.
// TESTING
//  1. Tokens (1,3),(0,2), dout_ready=1 -> data_out 1,1,1,0,0 on consecutive cycles;
//     dout_last on the 3rd and 5th bits; no bubble.
//  2. Token (0,4) with dout_ready toggling 1,0,1,0... -> four 0 bits, outputs stable on stall
//     cycles, dout_last only on the 4th transfer.
//  3. Token (1,0) then (0,1) -> err_zero pulses once, output is a single 0 bit.
//  4. Token (1,255) with COUNT_W=8 -> 255 ones, dout_last on transfer 255, FSM returns to IDLE.
//  5. rst asserted at bit 2 of (1,5) -> next cycle dout_valid=0, FSM IDLE, FIFO empty;
//     a following token (0,1) expands normally.
//  6. Loop-back: random bitstream -> vlc_count -> vlc_expand reproduces the stream bit-exact,
//     run both with and without VLC_EXPAND_FIFO_EN.

Source files
------------

// File: rtl/vlc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vlc_pkg : shared VLC constants, run-token type and expander FSM states   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package vlc_pkg;

  localparam int VLC_COUNT_W = 8;

  typedef struct packed {
    logic                   tok_type;
    logic [VLC_COUNT_W-1:0] count;
  } vlc_token_t;

  typedef enum logic [0:0] {
    VLC_EXP_IDLE = 1'b0,
    VLC_EXP_EMIT = 1'b1
  } vlc_exp_state_e;

endpackage
`default_nettype wire

// File: rtl/vlc_expand_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vlc_expand_if : token-in / serial-bit-out handshake bundle               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface vlc_expand_if #(
  parameter int COUNT_W = vlc_pkg::VLC_COUNT_W
);
  logic               type_in;
  logic [COUNT_W-1:0] count_in;
  logic               din_valid;
  logic               din_ready;
  logic               data_out;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_last;
  logic               err_zero;

  modport master (
    output type_in, count_in, din_valid, dout_ready,
    input  din_ready, data_out, dout_valid, dout_last, err_zero
  );

  modport slave (
    input  type_in, count_in, din_valid, dout_ready,
    output din_ready, data_out, dout_valid, dout_last, err_zero
  );
endinterface
`default_nettype wire

// File: rtl/vlc_token_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vlc_token_fifo : synchronous token FIFO, registered full/empty flags     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vlc_token_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             full_q;
  logic             empty_q;
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i & ~full_q;
  assign w_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (!w_push && w_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Flags come from the next count so they are plain flops at the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == (PTR_W+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule
`default_nettype wire

// File: rtl/vlc_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vlc_expand : run-length expander, (type,count) tokens -> serial bits     |
// | Optional token FIFO ahead of the FSM: define VLC_EXPAND_FIFO_EN          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vlc_expand
  import vlc_pkg::*;
#(
  parameter int COUNT_W = VLC_COUNT_W
`ifdef VLC_EXPAND_FIFO_EN
  , parameter int FIFO_DEPTH = 4
`endif
) (
  input  logic         clk,
  input  logic         rst,
  vlc_expand_if.slave  bus
);
  vlc_exp_state_e     state_q;
  vlc_exp_state_e     state_d;
  logic [COUNT_W-1:0] remaining_q;
  logic [COUNT_W-1:0] remaining_d;
  logic               cur_type_q;
  logic               cur_type_d;
  logic               err_zero_q;
  logic               err_zero_d;

  logic               w_last_xfer;
  logic               w_can_load;
  logic               w_din_fire;
  logic               w_zero_drop;
  logic               w_src_valid;
  logic               w_src_type;
  logic [COUNT_W-1:0] w_src_count;
  logic               w_load;

  assign w_last_xfer = (state_q == VLC_EXP_EMIT) && (remaining_q == COUNT_W'(1))
                       && bus.dout_ready;
  assign w_can_load  = (state_q == VLC_EXP_IDLE) || w_last_xfer;
  assign w_din_fire  = bus.din_valid & bus.din_ready;
  assign w_zero_drop = w_din_fire & (bus.count_in == '0);

`ifdef VLC_EXPAND_FIFO_EN
  logic [COUNT_W:0] w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  assign bus.din_ready = ~rst & ~w_fifo_full;

  // Zero-count tokens never enter the FIFO, so the head always carries a real run.
  vlc_token_fifo #(
    .WIDTH (COUNT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_din_fire & ~w_zero_drop),
    .wdata_i ({bus.type_in, bus.count_in}),
    .pop_i   (w_can_load & ~w_fifo_empty),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign w_src_valid = ~w_fifo_empty;
  assign w_src_type  = w_fifo_rdata[COUNT_W];
  assign w_src_count = w_fifo_rdata[COUNT_W-1:0];
`else
  assign bus.din_ready = ~rst & w_can_load;
  assign w_src_valid   = w_din_fire;
  assign w_src_type    = bus.type_in;
  assign w_src_count   = bus.count_in;
`endif

  assign w_load = w_src_valid & w_can_load & (w_src_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= VLC_EXP_IDLE;
      remaining_q <= '0;
      cur_type_q  <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_type_q  <= cur_type_d;
      err_zero_q  <= err_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_type_d  = cur_type_q;
    err_zero_d  = w_zero_drop;
    case (state_q)
      VLC_EXP_IDLE: begin
        if (w_load) begin
          state_d     = VLC_EXP_EMIT;
          remaining_d = w_src_count;
          cur_type_d  = w_src_type;
        end
      end
      VLC_EXP_EMIT: begin
        if (bus.dout_ready) begin
          if (remaining_q == COUNT_W'(1)) begin
            // Back-to-back reload on the final bit keeps the stream bubble-free.
            if (w_load) begin
              remaining_d = w_src_count;
              cur_type_d  = w_src_type;
            end else begin
              state_d     = VLC_EXP_IDLE;
              remaining_d = '0;
            end
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end
      default: state_d = VLC_EXP_IDLE;
    endcase
  end

  always_comb begin
    bus.dout_valid = 1'b0;
    bus.data_out   = 1'b0;
    bus.dout_last  = 1'b0;
    if (state_q == VLC_EXP_EMIT) begin
      bus.dout_valid = 1'b1;
      bus.data_out   = cur_type_q;
      bus.dout_last  = (remaining_q == COUNT_W'(1));
    end
  end

  assign bus.err_zero = err_zero_q;
endmodule
`default_nettype wire

// File: tb/tb_vlc_expand.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vlc_expand : randomized self-checking bench for vlc_expand            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vlc_expand;
  import vlc_pkg::*;

  localparam int CW = VLC_COUNT_W;

  typedef struct {logic b; logic last;}          bit_t;
  typedef struct {logic b; logic last; int cyc;} obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   err_cnt = 0;
  int   stall_cnt = 0;

  bit_t model[$];
  obs_t log_q[$];
  int   acc_cyc[$];

  logic zero_prev = 1'b0;
  logic stall_prev = 1'b0;
  logic prev_data = 1'b0;
  logic prev_last = 1'b0;
  bit_t e;

  vlc_expand_if #(.COUNT_W(CW)) bus ();

  vlc_expand #(.COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec model: every accepted token owes `count` bits of its type, the final one flagged last.
  always @(negedge clk) begin
    if (rst) begin
      model.delete();
      zero_prev  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("err_zero", bus.err_zero, zero_prev);
      if (bus.err_zero) err_cnt++;
      if (stall_prev) begin
        check("stall_valid", bus.dout_valid, 1);
        check("stall_data", bus.data_out, prev_data);
        check("stall_last", bus.dout_last, prev_last);
      end
`ifdef VLC_EXPAND_FIFO_EN
      if (bus.dout_valid) check("valid_owed", model.size() > 0, 1);
`else
      check("valid_timing", bus.dout_valid, model.size() > 0);
`endif
      if (bus.dout_valid && bus.dout_ready) begin
        if (model.size() == 0) begin
          check("spurious_bit", model.size(), 1);
        end else begin
          e = model.pop_front();
          check("data", bus.data_out, e.b);
          check("last", bus.dout_last, e.last);
        end
        log_q.push_back('{bus.data_out, bus.dout_last, cyc});
      end
      stall_prev = bus.dout_valid && !bus.dout_ready;
      if (stall_prev) stall_cnt++;
      prev_data  = bus.data_out;
      prev_last  = bus.dout_last;
      zero_prev  = bus.din_valid && bus.din_ready && (bus.count_in == '0);
      if (bus.din_valid && bus.din_ready) begin
        acc_cyc.push_back(cyc);
        for (int i = 1; i <= int'(bus.count_in); i++)
          model.push_back('{bus.type_in, i == int'(bus.count_in)});
      end
    end
  end

  // dout_ready: 0 = held high, 1 = toggling, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.dout_ready = ~bus.dout_ready;
        2:       bus.dout_ready = ($urandom_range(0, 3) != 0);
        default: bus.dout_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic t, input logic [CW-1:0] c);
    logic ok = 1'b0;
    bus.type_in   = t;
    bus.count_in  = c;
    bus.din_valid = 1'b1;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      ok = bus.din_ready;
    end
    check("send_accept", ok, 1);
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge clk);
      done = (model.size() == 0) && !bus.dout_valid;
    end
    check("drain_done", done, 1);
    #1;
  endtask

  task automatic check_log(input string name, input int n, input logic [7:0] bits,
                           input logic [7:0] lasts);
    check({name, "_len"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check({name, "_bit"}, log_q[i].b, bits[i]);
      check({name, "_last"}, log_q[i].last, lasts[i]);
    end
  endtask

  task automatic start_test(input int mode);
    rdy_mode        = mode;
    bus.dout_ready  = 1'b1;
    log_q.delete();
    acc_cyc.delete();
  endtask

  initial begin
    logic       stream[$];
    vlc_token_t runs[$];
    vlc_token_t t;
    logic       b;
    int         n1, nl, mism, e0;

    bus.type_in    = 1'b0;
    bus.count_in   = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_dout_last", bus.dout_last, 0);
    check("rst_err_zero", bus.err_zero, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // (1,3),(0,2) -> 1,1,1,0,0 with no bubble
    start_test(0);
    send(1'b1, 8'd3);
    send(1'b0, 8'd2);
    drain();
    check_log("t1", 5, 8'b0000_0111, 8'b0001_0100);
    if (log_q.size() == 5 && acc_cyc.size() > 0) begin
      check("t1_contiguous", log_q[4].cyc - log_q[0].cyc, 4);
`ifdef VLC_EXPAND_FIFO_EN
      check("t1_latency", log_q[0].cyc - acc_cyc[0], 2);
`else
      check("t1_latency", log_q[0].cyc - acc_cyc[0], 1);
`endif
    end

    // equal-type tokens are not merged
    start_test(0);
    send(1'b1, 8'd2);
    send(1'b1, 8'd1);
    drain();
    check_log("teq", 3, 8'b0000_0111, 8'b0000_0110);

    // (0,4) with toggling ready
    start_test(1);
    stall_cnt = 0;
    send(1'b0, 8'd4);
    drain();
    check_log("t2", 4, 8'b0000_0000, 8'b0000_1000);
    check("t2_stalls_seen", stall_cnt > 0, 1);

    // zero-count token then (0,1)
    start_test(0);
    e0 = err_cnt;
    send(1'b1, 8'd0);
    send(1'b0, 8'd1);
    drain();
    check("t3_err_pulses", err_cnt - e0, 1);
    check_log("t3", 1, 8'b0000_0000, 8'b0000_0001);

    // maximum run
    start_test(0);
    send(1'b1, 8'd255);
    drain();
    n1 = 0;
    nl = 0;
    foreach (log_q[i]) begin
      if (log_q[i].b) n1++;
      if (log_q[i].last) nl++;
    end
    check("t4_len", log_q.size(), 255);
    check("t4_ones", n1, 255);
    check("t4_last_count", nl, 1);
    if (log_q.size() == 255) check("t4_last_pos", log_q[254].last, 1);
    check("t4_idle", bus.dout_valid, 0);

    // reset in the middle of (1,5)
    start_test(0);
    send(1'b1, 8'd5);
    for (int k = 0; k < 100 && log_q.size() < 2; k++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_valid_after_rst", bus.dout_valid, 0);
    check("t5_last_after_rst", bus.dout_last, 0);
    check("t5_ready_after_rst", bus.din_ready, 1);
    log_q.delete();
    @(posedge clk);
    #1;
    send(1'b0, 8'd1);
    drain();
    check_log("t5", 1, 8'b0000_0000, 8'b0000_0001);

    // loop-back: random bitstream -> run-length encode -> expander -> same bits
    start_test(2);
    b = 1'($urandom_range(0, 1));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 20) b = ~b;
      stream.push_back(b);
    end
    for (int i = 0; i < 300; i++) stream.push_back(~b);
    for (int i = 0; i < 50; i++) stream.push_back(1'($urandom_range(0, 1)));
    t.tok_type = stream[0];
    t.count    = '0;
    foreach (stream[i]) begin
      if (stream[i] != t.tok_type || t.count == 8'd255) begin
        runs.push_back(t);
        t.tok_type = stream[i];
        t.count    = '0;
      end
      t.count = t.count + 1'b1;
    end
    runs.push_back(t);
    foreach (runs[i]) begin
      if ($urandom_range(0, 9) == 0) send(1'($urandom_range(0, 1)), 8'd0);
      send(runs[i].tok_type, runs[i].count);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    check("loop_len", log_q.size(), stream.size());
    mism = 0;
    for (int i = 0; i < stream.size() && i < log_q.size(); i++)
      if (log_q[i].b !== stream[i]) mism++;
    check("loop_bit_errors", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
